// File: rtl/median_pkg.sv
// Shared types and defaults for the median_rank rank-order filter.
package median_pkg;

  localparam int unsigned MED_SIZE = 8;
  localparam int unsigned MED_NPIX = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DONE
  } med_state_t;

  // Width of a rank / window index field; never narrower than one bit.
  function automatic int unsigned rank_w(input int unsigned npix);
    return (npix < 2) ? 1 : $clog2(npix);
  endfunction

endpackage

// File: rtl/median_maxscan.sv
// Running maximum and its index for one extraction pass over the window.
// Ties keep the first (lowest-index) candidate because only a strictly
// greater value replaces the held one.
module median_maxscan #(
  parameter int unsigned SIZE  = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [SIZE-1:0]  din,
  input  logic [IDX_W-1:0] din_idx,
  output logic [SIZE-1:0]  max_nx,
  output logic [IDX_W-1:0] idx_nx
);

  logic [SIZE-1:0]  max_q, max_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Value the scan holds once the current candidate is considered.
  always_comb begin
    max_nx = max_q;
    idx_nx = idx_q;
    if (en && (din > max_q)) begin
      max_nx = din;
      idx_nx = din_idx;
    end
    max_d = clr ? '0 : max_nx;
    idx_d = clr ? '0 : idx_nx;
  end

  // Running max and index registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      max_q <= '0;
      idx_q <= '0;
    end else begin
      max_q <= max_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/median_rank.sv
// Rank-order filter: serially loads an NPIX-pixel window, then finds the
// k-th largest pixel by repeated max-extraction passes of NPIX steps each.
// Optional run-time rank select: define MEDIAN_RANK_EN to add the RANK port;
// otherwise the rank is fixed at the median.
module median_rank
  import median_pkg::*;
#(
  parameter  int unsigned SIZE   = MED_SIZE,
  parameter  int unsigned NPIX   = MED_NPIX,
  localparam int unsigned RANK_W = rank_w(NPIX)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [SIZE-1:0]   DI,
  input  logic              DSI,
`ifdef MEDIAN_RANK_EN
  input  logic [RANK_W-1:0] RANK,
`endif
  output logic [SIZE-1:0]   DO,
  output logic              DSO,
  output logic              ERR
);

  localparam int unsigned       CNT_W    = $clog2(NPIX + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(NPIX);
  localparam logic [RANK_W-1:0] LAST     = RANK_W'(NPIX - 1);
  localparam logic [RANK_W-1:0] MID      = RANK_W'((NPIX - 1) / 2);

  med_state_t        state_q, state_d;
  logic [SIZE-1:0]   win_q [NPIX];
  logic [SIZE-1:0]   win_d [NPIX];
  logic [NPIX-1:0]   vld_q, vld_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [RANK_W-1:0] rank_q, rank_d;
  logic [RANK_W-1:0] pass_q, pass_d;
  logic [RANK_W-1:0] step_q, step_d;
  logic [SIZE-1:0]   do_q, do_d;
  logic              dso_q, dso_d;
  logic              err_q, err_d;

  logic [RANK_W-1:0] rank_in;
  logic              scan_en, scan_clr;
  logic [SIZE-1:0]   max_nx;
  logic [RANK_W-1:0] idx_nx;

  // Rank requested for the next sort, clamped into the window.
  always_comb begin
`ifdef MEDIAN_RANK_EN
    rank_in = (RANK > LAST) ? LAST : RANK;
`else
    rank_in = MID;
`endif
  end

  median_maxscan #(
    .SIZE  (SIZE),
    .IDX_W (RANK_W)
  ) u_maxscan (
    .clk     (CLK),
    .rst     (RST),
    .clr     (scan_clr),
    .en      (scan_en),
    .din     (win_q[step_q]),
    .din_idx (step_q),
    .max_nx  (max_nx),
    .idx_nx  (idx_nx)
  );

  // Next-state, window shift and sort sequencing.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    vld_d    = vld_q;
    cnt_d    = cnt_q;
    rank_d   = rank_q;
    pass_d   = pass_q;
    step_d   = step_q;
    do_d     = do_q;
    dso_d    = dso_q;
    err_d    = 1'b0;
    scan_en  = 1'b0;
    scan_clr = 1'b0;

    // Any accepted pixel shifts the window, whatever the state.
    if (DSI) begin
      win_d[0] = DI;
      for (int unsigned i = 1; i < NPIX; i++) begin
        win_d[i] = win_q[i-1];
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (DSI) begin
          cnt_d   = CNT_W'(1);
          dso_d   = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (DSI) begin
          cnt_d = (cnt_q == CNT_FULL) ? CNT_FULL : cnt_q + CNT_W'(1);
        end else if (cnt_q == CNT_FULL) begin
          vld_d    = '1;
          rank_d   = rank_in;
          pass_d   = '0;
          step_d   = '0;
          scan_clr = 1'b1;
          state_d  = SORT;
        end else begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      SORT: begin
        if (DSI) begin
          cnt_d   = CNT_W'(1);
          state_d = LOAD;
        end else begin
          scan_en = vld_q[step_q];
          // The last step of a pass acts on the combinational max so the
          // result lands on the same edge that examines R[NPIX-1].
          if (step_q == LAST) begin
            if (pass_q == rank_q) begin
              do_d    = max_nx;
              dso_d   = 1'b1;
              state_d = DONE;
            end else begin
              vld_d[idx_nx] = 1'b0;
              scan_clr      = 1'b1;
              pass_d        = pass_q + RANK_W'(1);
              step_d        = '0;
            end
          end else begin
            step_d = step_q + RANK_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, window and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      for (int unsigned i = 0; i < NPIX; i++) begin
        win_q[i] <= '0;
      end
      vld_q  <= '0;
      cnt_q  <= '0;
      rank_q <= '0;
      pass_q <= '0;
      step_q <= '0;
      do_q   <= '0;
      dso_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int unsigned i = 0; i < NPIX; i++) begin
        win_q[i] <= win_d[i];
      end
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
      rank_q <= rank_d;
      pass_q <= pass_d;
      step_q <= step_d;
      do_q   <= do_d;
      dso_q  <= dso_d;
      err_q  <= err_d;
    end
  end

  assign DO  = do_q;
  assign DSO = dso_q;
  assign ERR = err_q;

endmodule

// File: tb/tb_median_rank.sv
// Directed bench for median_rank (NPIX=9, SIZE=8); covers the run-time
// rank cases only when MEDIAN_RANK_EN is defined.
module tb_median_rank;

  logic       CLK = 1'b0;
  logic       RST;
  logic       DSI;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       DSO;
  logic       ERR;
`ifdef MEDIAN_RANK_EN
  logic [3:0] RANK;
`endif

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] frm [$];

  median_rank #(
    .SIZE (8),
    .NPIX (9)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .DI   (DI),
    .DSI  (DSI),
`ifdef MEDIAN_RANK_EN
    .RANK (RANK),
`endif
    .DO   (DO),
    .DSO  (DSO),
    .ERR  (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive one cycle; returns 1ns after the edge that sampled the inputs.
  task automatic step(input logic dsi, input logic [7:0] di);
    DSI = dsi;
    DI  = di;
    @(posedge CLK);
    #1;
  endtask

  task automatic load_frame(input string tag);
    foreach (frm[i]) begin
      step(1'b1, frm[i]);
      if (i == 0) chk({tag, "_dso_fall"}, 32'(DSO), 32'd0);
    end
  endtask

  // Cycles from E0 until DSO rises; -1 if it never does within the bound.
  task automatic wait_dso(output int lat);
    lat = 0;
    while (DSO !== 1'b1 && lat < 200) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    if (DSO !== 1'b1) lat = -1;
  endtask

  task automatic run(input string tag, input logic [7:0] exp_do, input int exp_lat);
    int lat;
    load_frame(tag);
    step(1'b0, 8'd0);
    chk({tag, "_err"}, 32'(ERR), 32'd0);
    wait_dso(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_do"}, 32'(DO), 32'(exp_do));
  endtask

  initial begin
    RST = 1'b1;
    DSI = 1'b0;
    DI  = '0;
`ifdef MEDIAN_RANK_EN
    RANK = 4'd4;
`endif
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_do", 32'(DO), 32'd0);
    chk("rst_dso", 32'(DSO), 32'd0);
    chk("rst_err", 32'(ERR), 32'd0);
    RST = 1'b0;
    step(1'b0, 8'd0);

    // Median of a scrambled frame; result holds in DONE.
    frm = '{30, 90, 10, 70, 50, 20, 80, 60, 40};
    run("med", 8'd50, 45);
    repeat (3) step(1'b0, 8'd0);
    chk("hold_dso", 32'(DSO), 32'd1);
    chk("hold_do", 32'(DO), 32'd50);

    frm = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
`ifdef MEDIAN_RANK_EN
    RANK = 4'd0;
    run("r0_seq", 8'd9, 9);
    RANK = 4'd8;
    run("r8_seq", 8'd1, 81);
    RANK = 4'd15;
    run("r15_clamp", 8'd1, 81);
    RANK = 4'd4;
`endif
    run("seq", 8'd5, 45);

    frm = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
`ifdef MEDIAN_RANK_EN
    RANK = 4'd0;
    run("r0_tie", 8'd7, 9);
    RANK = 4'd8;
    run("r8_tie", 8'd7, 81);
    RANK = 4'd4;
`endif
    run("tie", 8'd7, 45);

    // Over-long frame keeps only the last nine pixels.
    frm = '{100, 200, 1, 2, 3, 4, 5, 6, 7, 8, 9};
    run("long", 8'd5, 45);

    // Short frame: discarded with a one-cycle error pulse.
    frm = '{11, 22, 33, 44, 55};
    load_frame("short");
    step(1'b0, 8'd0);
    chk("short_err_hi", 32'(ERR), 32'd1);
    chk("short_dso", 32'(DSO), 32'd0);
    chk("short_do", 32'(DO), 32'd5);
    step(1'b0, 8'd0);
    chk("short_err_lo", 32'(ERR), 32'd0);
    repeat (50) step(1'b0, 8'd0);
    chk("short_idle_dso", 32'(DSO), 32'd0);
    chk("short_idle_do", 32'(DO), 32'd5);

    // Abort a sort ten cycles in by starting a new frame.
    frm = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
    load_frame("abort_a");
    step(1'b0, 8'd0);
    repeat (9) step(1'b0, 8'd0);
    chk("abort_dso", 32'(DSO), 32'd0);
    chk("abort_do", 32'(DO), 32'd5);
    frm = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    run("abort_b", 8'd4, 45);

    // Reset in the middle of a sort clears outputs at once.
    frm = '{30, 90, 10, 70, 50, 20, 80, 60, 40};
    load_frame("rst_mid");
    step(1'b0, 8'd0);
    repeat (20) step(1'b0, 8'd0);
    RST = 1'b1;
    #2;
    chk("rst_mid_do", 32'(DO), 32'd0);
    chk("rst_mid_dso", 32'(DSO), 32'd0);
    chk("rst_mid_err", 32'(ERR), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    step(1'b0, 8'd0);
    frm = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    run("post_rst", 8'd4, 45);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/median_rank.md
# median_rank

Parametrised rank-order filter, successor to the fixed 9-pixel median block of the image pipeline. Loads a window of `NPIX` pixels serially, then extracts the k-th largest value by repeated max-extraction passes. The default rank is the median, and the rank is selectable at run time. Sits between the pixel line buffer and the output stage, with the same DSI/DSO framing as the existing filter.

## Interface
- `SIZE`, 8, pixel width in bits.
- `NPIX`, 9, window size; odd, 3..15.
- `RANK_W`, `$clog2(NPIX)`, width of the rank field; derived, not overridden.
- `CLK`  in  1  single clock, rising edge.
- `RST`  in  1  reset; asynchronous, active-high.
- `DI`  in  SIZE  pixel input, sampled when DSI=1.
- `DSI`  in  1  load strobe; high for each pixel of a frame.
- `RANK`  in  RANK_W  requested rank, 0 = max, NPIX-1 = min. Present only with MEDIAN_RANK_EN.
- `DO`  out  SIZE  filtered result; held between frames.
- `DSO`  out  1  result valid; level signal.
- `ERR`  out  1  one-cycle pulse on a discarded short frame.

## Operation
- Reset values:
  - State is IDLE.
  - All window registers R[0..NPIX-1] = 0.
  - Valid bits = 0, pixel count = 0.
  - DO = 0, DSO = 0, ERR = 0.
- States: IDLE, LOAD, SORT, DONE.
- IDLE/DONE, DSI=1: go to LOAD.
  - Shift DI into R[0]; R[i] moves to R[i+1].
  - Count = 1. DSO clears at this same edge.
- LOAD, DSI=1: shift, count saturates at NPIX. A frame longer than NPIX keeps the last NPIX pixels.
- LOAD, DSI=0:
  - If count == NPIX: go to SORT. All valid bits set, rank latched (clamped to NPIX-1), pass p = 0, step s = 0, running max cleared.
  - If count < NPIX: frame is discarded. ERR = 1 for one cycle, go to IDLE, DO unchanged.
- SORT: each pass is exactly NPIX steps. Step s examines R[s]. If valid and R[s] > running max, running max and its index are updated.
  - Ties keep the lowest index. Comparison is unsigned.
- End of pass p < rank: clear the valid bit of the max index, reset the running max, p++.
- End of pass p == rank: DO <= running max, DSO <= 1, go to DONE.
- DONE: DO and DSO hold until DSI rises.
- DSI=1 during SORT: abort the sort and restart the load with this pixel (LOAD, count = 1). DO keeps its previous value; DSO stays 0.
- RST asserted in any state: immediate return to reset values; no partial result is emitted.

## Timing
- Load: one pixel per cycle; no back-pressure.
- E0 is the edge that samples DSI=0 with count == NPIX. DSO rises and DO updates at the edge (RANK+1)·NPIX cycles after E0.
  - Default median (NPIX=9, rank 4): 45 cycles.
  - Max: NPIX cycles. Min: NPIX² cycles.
- DSO falls at the edge that samples DSI=1.
- ERR is high for exactly the cycle after the edge that samples the short frame's DSI=0.
- The DO update and the DSO rise happen at the same edge; no combinational path from DI or DSI to DO.

## Configuration
- `MEDIAN_RANK_EN` defined:
  - The RANK port exists.
  - Rank is latched from the port at E0.
  - Out-of-range values clamp to NPIX-1.
- Undefined:
  - The RANK port is absent.
  - Rank is the constant (NPIX-1)/2.
  - Latency is fixed at ((NPIX+1)/2)·NPIX.

## Structure
- Package `median_pkg`:
  - State enum `med_state_t` (IDLE, LOAD, SORT, DONE).
  - `function rank_w(npix)`.
  - Default constants `MED_SIZE` = 8, `MED_NPIX` = 9.
- Sub-module `median_maxscan`: running-max register plus index, with compare/update enable and clear.
- The top level holds the shift window, valid bits, counters and FSM.

## Test plan
- Frame 30,90,10,70,50,20,80,60,40 (NPIX=9, default rank) -> DO=50, DSO high exactly 45 cycles after E0, ERR=0.
- Nine pixels all 7, then RANK=0 and RANK=8 (MEDIAN_RANK_EN) -> DO=7 each time; latencies 9 and 81 cycles.
- Frame 1..9 with RANK=0 -> DO=9; RANK=8 -> DO=1; RANK=15 -> clamped, DO=1.
- Eleven pixels 100,200,1..9 -> the first two are dropped, DO=5.
- Five pixels then DSI=0 -> ERR pulses for one cycle, state IDLE, DO keeps the prior value, DSO=0.
- DSI re-asserted 10 cycles into SORT with a new frame 0..8 -> no DSO for the aborted frame, then DO=4. Separately, RST pulsed mid-SORT -> DO=0, DSO=0 immediately.
